// File: rtl/mousetrap_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mousetrap_pkg
//  Purpose  : Shared constants, types and width helpers for the MouseTrap
//             synchronous receiver and its FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
package mousetrap_pkg;

    // Default width of one bundled-data word
    localparam int DEFAULT_WORD_WIDTH = 32;

    // One word at the default width
    typedef logic [DEFAULT_WORD_WIDTH-1:0] word_t;

    // Pointer width for a FIFO of the given depth (never narrower than 1 bit)
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mousetrap_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : mousetrap_rx_fifo
//  Purpose  : Synchronous FIFO behind the MouseTrap receiver. Registered
//             storage, naturally wrapping pointers and a separate occupancy
//             counter. No fall-through: a word written at an edge becomes
//             visible at the head only after that edge.
//  Revision : 1.0 - initial release
// ============================================================================
module mousetrap_rx_fifo
    import mousetrap_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [WORD_WIDTH-1:0]   wr_data,
    input  logic                    rd_en,
    output logic [WORD_WIDTH-1:0]   rd_data,
    output logic                    valid,
    output logic                    full,
    output logic [ptr_w(DEPTH):0]   level
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] C_DEPTH = LVL_W'(DEPTH);

    logic [WORD_WIDTH-1:0] mem_q [DEPTH];
    logic [WORD_WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      count_q,  count_d;

    logic w_wr_fire;
    logic w_rd_fire;

    // A full FIFO refuses writes even when a read fires in the same cycle
    assign w_wr_fire = wr_en && (count_q != C_DEPTH);
    assign w_rd_fire = rd_en && (count_q != '0);

    // Next-state for storage, pointers and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_wr_fire) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (w_rd_fire) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({w_wr_fire, w_rd_fire})
            2'b10:   count_d = count_q + LVL_W'(1);
            2'b01:   count_d = count_q - LVL_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; storage is cleared so the head reads 0 after reset
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign valid   = (count_q != '0);
    assign full    = (count_q == C_DEPTH);
    assign level   = count_q;

endmodule
`default_nettype wire

// File: rtl/mousetrap_sync_rx.sv
`default_nettype none
// ============================================================================
//  Module   : mousetrap_sync_rx
//  Purpose  : Terminates a MouseTrap two-phase bundled-data pipeline. The
//             final req is synchronized into clk, bundled data is captured
//             into a small FIFO, ack toggles only when there is room, and
//             words leave on a valid/ready stream.
//  Options  : MOUSETRAP_RX_COUNT_EN adds a 32-bit accepted-word counter
//             output rx_count.
//  Revision : 1.0 - initial release
// ============================================================================
module mousetrap_sync_rx
    import mousetrap_pkg::*;
#(
    parameter int WORD_WIDTH  = DEFAULT_WORD_WIDTH,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_in,
    input  logic [WORD_WIDTH-1:0]   data_in,
    output logic                    ack_out,
    output logic                    m_valid,
    output logic [WORD_WIDTH-1:0]   m_data,
    input  logic                    m_ready,
    output logic [ptr_w(DEPTH):0]   level
`ifdef MOUSETRAP_RX_COUNT_EN
    ,
    output logic [31:0]             rx_count
`endif
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   ack_q,  ack_d;

    logic w_req_s;
    logic w_pending;
    logic w_accept;
    logic w_full;
    logic w_rd_en;

    // req_in is asynchronous; only the last synchronizer flop is trusted
    assign w_req_s   = sync_q[SYNC_STAGES-1];
    // An unacknowledged phase exists whenever the synchronized req differs from ack
    assign w_pending = w_req_s ^ ack_q;
    // data_in is sampled raw: the sender holds it until ack toggles and
    // req_s lags req_in by the synchronizer depth, so it is long settled
    assign w_accept  = w_pending && !w_full;
    assign w_rd_en   = m_ready;

    // Synchronizer shift and ack toggle on accept
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], req_in};
        ack_d  = ack_q ^ w_accept;
    end

    // Synchronizer and ack registers
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            ack_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            ack_q  <= ack_d;
        end
    end

    assign ack_out = ack_q;

    mousetrap_rx_fifo #(
        .DEPTH      (DEPTH),
        .WORD_WIDTH (WORD_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_accept),
        .wr_data (data_in),
        .rd_en   (w_rd_en),
        .rd_data (m_data),
        .valid   (m_valid),
        .full    (w_full),
        .level   (level)
    );

`ifdef MOUSETRAP_RX_COUNT_EN
    logic [31:0] rx_count_q, rx_count_d;

    // Count every accepted word, wrapping at 2^32
    always_comb begin
        rx_count_d = rx_count_q + 32'(w_accept);
    end

    // Accepted-word counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_count_q <= '0;
        end else begin
            rx_count_q <= rx_count_d;
        end
    end

    assign rx_count = rx_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mousetrap_sync_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mousetrap_sync_rx
//  Purpose  : Self-checking bench for mousetrap_sync_rx. A behavioural
//             two-phase sender drives the receiver; issued words go to a
//             scoreboard queue that a monitor pops as the stream delivers.
//             A queue-based reference model tracks ack, occupancy and head.
//  Options  : MOUSETRAP_RX_COUNT_EN enables rx_count checking.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mousetrap_sync_rx;
    import mousetrap_pkg::*;

    localparam int DEPTH = 4;
    localparam int SYNC  = 2;
    localparam int LW    = 3;
    localparam int LIMIT = 200;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_in;
    word_t         data_in;
    logic          ack_out;
    logic          m_valid;
    word_t         m_data;
    logic          m_ready;
    logic [LW-1:0] level;
`ifdef MOUSETRAP_RX_COUNT_EN
    logic [31:0]   rx_count;
`endif

    mousetrap_sync_rx #(
        .WORD_WIDTH  (32),
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req_in  (req_in),
        .data_in (data_in),
        .ack_out (ack_out),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_ready (m_ready),
        .level   (level)
`ifdef MOUSETRAP_RX_COUNT_EN
        ,
        .rx_count(rx_count)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard: words in the order the sender issued them
    word_t exp_q[$];
    logic  sender_busy = 1'b0;

    // Reference model: a word queue, the ack phase, and the req value as the
    // receiver sees it SYNC edges after it was driven
    word_t       mdl_q[$];
    logic        mdl_ack = 1'b0;
    logic        mdl_req_seen[$];
    int unsigned mdl_acc = 0;
    logic        mdl_run = 1'b0;
    logic        mdl_pop, mdl_take;

    always @(posedge clk) begin
        if (reset) begin
            mdl_q.delete();
            mdl_ack = 1'b0;
            mdl_req_seen.delete();
            for (int i = 0; i < SYNC; i++) mdl_req_seen.push_back(1'b0);
            mdl_acc = 0;
            mdl_run = 1'b1;
        end else if (mdl_run) begin
            mdl_pop  = (mdl_q.size() > 0) && m_ready;
            mdl_take = (mdl_req_seen[0] != mdl_ack) && (mdl_q.size() < DEPTH);
            if (mdl_pop) void'(mdl_q.pop_front());
            if (mdl_take) begin
                mdl_q.push_back(data_in);
                mdl_ack = ~mdl_ack;
                mdl_acc++;
            end
            void'(mdl_req_seen.pop_front());
            mdl_req_seen.push_back(req_in);
        end
    end

    // Monitor: compare against the model and pop the scoreboard on delivery
    always @(negedge clk) begin
        if (mdl_run) begin
            check("ack_out", 64'(ack_out), 64'(mdl_ack));
            check("level", 64'(level), 64'(mdl_q.size()));
            check("m_valid", 64'(m_valid), 64'(mdl_q.size() > 0));
            if (mdl_q.size() > 0) check("m_data_head", 64'(m_data), 64'(mdl_q[0]));
`ifdef MOUSETRAP_RX_COUNT_EN
            check("rx_count", 64'(rx_count), 64'(mdl_acc));
`endif
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_underflow", 64'(m_data), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    check("scoreboard_order", 64'(m_data), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    // Two-phase sender: a new phase only once the previous one is acknowledged
    task automatic send_word(input word_t w);
        int n = 0;
        while (ack_out != req_in && n < LIMIT) begin
            @(posedge clk); #1;
            n++;
        end
        check("send_wait_timeout", 64'(n < LIMIT), 64'd1);
        data_in = w;
        req_in  = ~req_in;
        exp_q.push_back(w);
        @(posedge clk); #1;
    endtask

    task automatic wait_drained(input string name);
        int n = 0;
        while (!(exp_q.size() == 0 && !sender_busy) && n < LIMIT) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, 64'(n < LIMIT), 64'd1);
    endtask

    // Random traffic: random sender gaps and random consumer readiness
    task automatic run_random(input int nwords);
        int n = 0;
        sender_busy = 1'b1;
        fork
            begin
                for (int i = 0; i < nwords; i++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    send_word(word_t'($urandom));
                end
                sender_busy = 1'b0;
            end
            begin
                while (!(exp_q.size() == 0 && !sender_busy) && n < 3000) begin
                    m_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                    n++;
                end
                m_ready = 1'b0;
                check("random_drain_timeout", 64'(n < 3000), 64'd1);
            end
        join
    endtask

    int   toggles;
    logic prev_ack;

    initial begin
        reset   = 1'b1;
        req_in  = 1'b0;
        m_ready = 1'b0;
        data_in = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack_out", 64'(ack_out), 64'd0);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        check("rst_m_data", 64'(m_data), 64'd0);
`ifdef MOUSETRAP_RX_COUNT_EN
        check("rst_rx_count", 64'(rx_count), 64'd0);
`endif
        reset = 1'b0;

        // Single word: accepted on the third edge after the req toggle
        data_in = 32'hDEADBEEF;
        req_in  = 1'b1;
        exp_q.push_back(32'hDEADBEEF);
        @(posedge clk); #1;
        check("lat_edge1_ack", 64'(ack_out), 64'd0);
        @(posedge clk); #1;
        check("lat_edge2_ack", 64'(ack_out), 64'd0);
        check("lat_edge2_valid", 64'(m_valid), 64'd0);
        @(posedge clk); #1;
        check("lat_edge3_ack", 64'(ack_out), 64'd1);
        check("lat_edge3_valid", 64'(m_valid), 64'd1);
        check("lat_edge3_data", 64'(m_data), 64'hDEADBEEF);
        check("lat_edge3_level", 64'(level), 64'd1);
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        check("single_pop_level", 64'(level), 64'd0);

        // Backpressure: six words into a four-entry FIFO with no reads
        sender_busy = 1'b1;
        fork
            begin
                for (int w = 1; w <= 6; w++) send_word(word_t'(w));
                sender_busy = 1'b0;
            end
        join_none
        toggles  = 0;
        prev_ack = ack_out;
        repeat (40) begin
            @(posedge clk); #1;
            if (ack_out != prev_ack) toggles++;
            prev_ack = ack_out;
        end
        check("bp_ack_toggles", 64'(toggles), 64'd4);
        check("bp_level_full", 64'(level), 64'd4);
        check("bp_word5_pending", 64'(req_in ^ ack_out), 64'd1);

        // Full with simultaneous read: pop only, then the stalled word lands
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        check("full_read_level", 64'(level), 64'd3);
        @(posedge clk); #1;
        check("full_refill_level", 64'(level), 64'd4);

        // Drain in order 1..6
        m_ready = 1'b1;
        wait_drained("bp_drain_timeout");
        m_ready = 1'b0;
        @(posedge clk); #1;

        // Reset mid-transfer with a phase in flight; pipeline resets too
        send_word(32'h11);
        send_word(32'h12);
        begin
            int n = 0;
            while (level != LW'(2) && n < LIMIT) begin @(posedge clk); #1; n++; end
            check("mid_level_two", 64'(level), 64'd2);
        end
        send_word(32'h13);
        reset  = 1'b1;
        req_in = 1'b0;
        exp_q.delete();
        repeat (2) begin @(posedge clk); #1; end
        check("mid_rst_level", 64'(level), 64'd0);
        check("mid_rst_ack", 64'(ack_out), 64'd0);
        check("mid_rst_valid", 64'(m_valid), 64'd0);
        reset = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        check("post_rst_level", 64'(level), 64'd0);
        check("post_rst_ack", 64'(ack_out), 64'd0);

        // Ten words after reset, then a longer random run
        run_random(10);
`ifdef MOUSETRAP_RX_COUNT_EN
        check("rx_count_ten", 64'(rx_count), 64'd10);
`endif
        run_random(30);
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
